// File: rtl/bp_seq_pkg.sv
// Shared types for the training-run sequencer: state encoding, cost width
// and the saturating add used by the cost accumulator.
package bp_seq_pkg;

  localparam int COST_W = 32;

  // state  | meaning
  // IDLE   | waiting for a start edge (ready=1)
  // FWD    | forward pulse issued
  // WFWD   | waiting for fwd_done
  // BWD    | backward pulse issued
  // WBWD   | waiting for bwd_done
  // UPD    | weight-update pulse issued
  // WUPD   | waiting for upd_done
  // NEXT   | advance sample/epoch, publish epoch cost at epoch end
  // FIN    | set done, return to IDLE
  // ERR    | phase timeout, held until reset
  typedef enum logic [3:0] {
    S_IDLE, S_FWD, S_WFWD, S_BWD, S_WBWD, S_UPD, S_WUPD, S_NEXT, S_FIN, S_ERR
  } state_t;

  function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                input logic [COST_W-1:0] b);
    logic [COST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COST_W] ? '1 : s[COST_W-1:0];
  endfunction

endpackage

// File: rtl/bp_seq_wdog.sv
// Per-phase watchdog for bp_seq_ctrl; only built when BP_SEQ_TIMEOUT_EN is defined.
`ifdef BP_SEQ_TIMEOUT_EN
module bp_seq_wdog #(
  parameter int TO_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) cnt <= '0;
    else if (run && !expired) cnt <= cnt + CW'(1);
  end

  // Fires in the TO_CYCLES-th consecutive wait cycle.
  assign expired = run && (cnt == CW'(TO_CYCLES - 1));

endmodule
`endif

// File: rtl/bp_seq_ctrl.sv
// Forward/backward/update training-run sequencer with per-epoch cost accumulation.
// Define BP_SEQ_TIMEOUT_EN to add the per-phase watchdog and the ERR state.
module bp_seq_ctrl
  import bp_seq_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int N_EPOCHS  = 16,
  parameter int TO_CYCLES = 1024,
  localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int EW = (N_EPOCHS > 1) ? $clog2(N_EPOCHS) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              mode_test,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic              fwd_start,
  input  logic              fwd_done,
  output logic              bwd_start,
  input  logic              bwd_done,
  output logic              upd_start,
  input  logic              upd_done,
  output logic [SW-1:0]     sample_idx,
  output logic [EW-1:0]     epoch_idx,
  input  logic [COST_W-1:0] cost_in,
  input  logic              cost_valid,
  output logic [COST_W-1:0] out_cost
);

  state_t              state;
  logic                start_q;
  logic                mode_q;
  logic [COST_W-1:0]   acc;
  logic [COST_W-1:0]   acc_nxt;
  logic                rise;
  logic                last_s;
  logic                last_e;
  logic                tmo;

  assign rise    = start & ~start_q;
  assign acc_nxt = sat_add(acc, cost_valid ? cost_in : '0);
  assign last_s  = (sample_idx == SW'(N_SAMPLES - 1));
  assign last_e  = (epoch_idx == EW'(N_EPOCHS - 1));
  assign ready   = (state == S_IDLE);

`ifdef BP_SEQ_TIMEOUT_EN
  logic wd_clr;
  logic wd_run;

  assign wd_clr = state inside {S_FWD, S_BWD, S_UPD};
  assign wd_run = state inside {S_WFWD, S_WBWD, S_WUPD};

  bp_seq_wdog #(.TO_CYCLES(TO_CYCLES)) u_wdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (wd_clr),
    .run     (wd_run),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      fwd_start  <= 1'b0;
      bwd_start  <= 1'b0;
      upd_start  <= 1'b0;
      sample_idx <= '0;
      epoch_idx  <= '0;
      acc        <= '0;
      out_cost   <= '0;
    end else begin
      start_q   <= start;
      fwd_start <= 1'b0;
      bwd_start <= 1'b0;
      upd_start <= 1'b0;
      if (state != S_IDLE) acc <= acc_nxt;
      case (state)
        S_IDLE: if (rise) begin
          state      <= S_FWD;
          fwd_start  <= 1'b1;
          done       <= 1'b0;
          mode_q     <= mode_test;
          sample_idx <= '0;
          epoch_idx  <= '0;
        end
        S_FWD: state <= S_WFWD;
        S_WFWD: begin
          if (fwd_done) begin
            if (mode_q) state <= S_NEXT;
            else begin
              state     <= S_BWD;
              bwd_start <= 1'b1;
            end
          end else if (tmo) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_BWD: state <= S_WBWD;
        S_WBWD: begin
          if (bwd_done) begin
            state     <= S_UPD;
            upd_start <= 1'b1;
          end else if (tmo) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_UPD: state <= S_WUPD;
        S_WUPD: begin
          if (upd_done) state <= S_NEXT;
          else if (tmo) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_NEXT: begin
          if (!last_s) begin
            sample_idx <= sample_idx + SW'(1);
            state      <= S_FWD;
            fwd_start  <= 1'b1;
          end else begin
            // Epoch end: publish including any cost arriving this cycle.
            sample_idx <= '0;
            out_cost   <= acc_nxt;
            acc        <= '0;
            if (mode_q || last_e) state <= S_FIN;
            else begin
              epoch_idx <= epoch_idx + EW'(1);
              state     <= S_FWD;
              fwd_start <= 1'b1;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
